cfo_loop_ctrl: RTL and testbench
================================

// Module: cfo_loop_ctrl
// PURPOSE
//   Acquisition/tracking sequencer for the CFO PI loop filter. Observes the phase-error stream feeding the filter.
//   Builds a windowed |err| lock metric and runs an IDLE/ACQ/TRACK FSM.
//   Drives the filter's gain shifts (wide in ACQ, narrow in TRACK), integrator clear and hold.
//   Sits beside the loop filter between the phase detector and the NCO.
// PARAMETERS
//   ERR_WIDTH    24    width of phase_err_i, Q1.(ERR_WIDTH-1)
//   WIN_LOG2     6     metric window = 2**WIN_LOG2 valid errors
//   LOCK_THR     24'h020000  window mean |err| below this = good window
//   UNLOCK_THR   24'h080000  window mean |err| above this = bad window; must be >= LOCK_THR
//   LOCK_CNT     3     consecutive good windows ACQ->TRACK
//   LOSS_CNT     2     consecutive bad windows TRACK->ACQ
//   ACQ_TIMEOUT  256   windows in ACQ before forced restart
//   KP_SH_ACQ 8, KI_SH_ACQ 14, KP_SH_TRK 12, KI_SH_TRK 20   right-shift gains, 5-bit each
// PORTS
//   clk             in   1          clock
//   rst             in   1          synchronous, active-high reset
//   enable_i        in   1          run loop; low forces IDLE
//   err_valid_i     in   1          phase error strobe
//   phase_err_i     in   ERR_WIDTH  signed phase error
//   kp_shift_o      out  5          proportional gain shift to loop filter
//   ki_shift_o      out  5          integral gain shift to loop filter
//   lf_clr_o        out  1          1-cycle integrator clear pulse
//   lf_hold_o       out  1          freeze loop filter (high in IDLE)
//   locked_o        out  1          high in TRACK
//   state_o         out  2          0 IDLE, 1 ACQ, 2 TRACK
//   metric_o        out  ERR_WIDTH  last window mean |err| (unsigned)
//   metric_valid_o  out  1          1-cycle strobe with metric_o
// BEHAVIOUR
//   Reset: state IDLE, kp/ki = ACQ shifts, lf_clr_o 0, lf_hold_o 1, locked_o 0, metric_o 0, metric_valid_o 0,
//   all counters 0.
//   |err|: two's-complement abs; most-negative input saturates to 2**(ERR_WIDTH-1)-1.
//   Accumulator is ERR_WIDTH+WIN_LOG2 bits unsigned and cannot overflow.
//   Accumulation happens only on err_valid_i.
//   Window end: on the edge accepting the 2**WIN_LOG2-th sample, the block registers:
//     - metric_o = full sum >> WIN_LOG2 and metric_valid_o = 1;
//     - the FSM decision;
//     - the accumulator and count, both cleared.
//   Latency: 1 cycle from the last err_valid_i to metric_valid_o and the state change.
//   FSM:
//     IDLE -> ACQ when enable_i=1; lf_clr_o pulses on entry.
//     ACQ at window end:
//       - good window: good_cnt++, else good_cnt=0;
//       - good_cnt==LOCK_CNT -> TRACK;
//       - otherwise acq_win++; acq_win==ACQ_TIMEOUT -> re-enter ACQ (lf_clr_o pulse, counters cleared).
//     TRACK at window end:
//       - bad window: bad_cnt++, else bad_cnt=0;
//       - bad_cnt==LOSS_CNT -> ACQ with lf_clr_o pulse.
//     Windows between the thresholds reset neither good_cnt nor bad_cnt (hysteresis).
//   Any state with enable_i=0 -> IDLE next edge:
//     - the accumulator and all counters clear;
//     - enable_i=0 overrides a coincident window end, and no metric strobe is produced.
//   Every state transition clears the window accumulator/count and good/bad/acq counters.
//   kp/ki_shift_o, locked_o, lf_hold_o and state_o are registered and change on the same edge as the state.
//   lf_clr_o is high exactly the cycle after that edge... no: lf_clr_o is asserted on the transition edge
//   for one cycle, coincident with the new shifts.
//   A sample arriving in the lf_clr_o cycle is the first sample of the new window.
//   rst mid-window: everything returns to reset values next edge; partial window discarded.
// CONFIGURATION
//   CFO_CTRL_STATS_EN defined: adds outputs
//     - lock_cnt_o [15:0]: increments on each ACQ->TRACK;
//     - loss_cnt_o [15:0]: increments on each TRACK->ACQ;
//     - timeout_cnt_o [15:0]: increments on each ACQ timeout.
//   All three saturate at 16'hFFFF, are cleared by rst only (not by enable_i), and are registered.
//   Undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//   cfo_ctrl_pkg:
//     - cfo_state_t enum (IDLE=0, ACQ=1, TRACK=2);
//     - SHIFT_W=5;
//     - the saturating abs function.
//   Sub-module cfo_lock_metric (abs, accumulate, window count, metric_o/metric_valid_o).
//   The FSM and gain decode stay in cfo_loop_ctrl.
// TESTING (WIN_LOG2=2, LOCK_CNT=3, LOSS_CNT=2, ACQ_TIMEOUT=4 unless noted)
//   1. rst then enable_i=1 -> next edge state_o=1, lf_clr_o one cycle, kp/ki=8/14, lf_hold_o=0.
//   2. 12 errors of 24'h000100 -> 3 metric strobes of 24'h000100, 1 cycle after each 4th valid.
//      TRACK after the 3rd strobe: kp/ki=12/20, locked_o=1, no lf_clr_o.
//   3. In TRACK, 8 errors of 24'h100000 -> TRACK->ACQ on the 2nd strobe with a lf_clr_o pulse.
//      A mid-band window (24'h040000) between two bad windows resets nothing, so 2 bad windows still trip loss.
//   4. In ACQ, 16 errors of 24'h7FFFFF -> restart lf_clr_o after the 4th window; state stays ACQ.
//      With CFO_CTRL_STATS_EN, timeout_cnt_o=1.
//   5. Error 24'h800000 x4 -> metric_o=24'h7FFFFF (abs saturation).
//      enable_i=0 on the 4th valid -> IDLE, no metric_valid_o, lf_hold_o=1.
//   6. rst after 2 samples of a window, then re-enable -> first metric appears only after 4 fresh samples.

Source files
------------

// File: rtl/cfo_ctrl_pkg.sv
// Shared types and helpers for the CFO loop acquisition/tracking controller.
package cfo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } cfo_state_t;

    localparam int SHIFT_W = 5;

    // Two's-complement magnitude of a w-bit value (sign-extended into v);
    // the most-negative code saturates to the largest positive code.
    function automatic logic [63:0] sat_abs(input logic signed [63:0] v, input int w);
        logic signed [63:0] most_neg;
        most_neg = -(64'sd1 <<< (w - 1));
        if (v == most_neg)
            sat_abs = (64'd1 << (w - 1)) - 64'd1;
        else if (v < 0)
            sat_abs = -v;
        else
            sat_abs = v;
    endfunction

endpackage

// File: rtl/cfo_lock_metric.sv
// Windowed mean-|err| lock metric: accumulates 2**WIN_LOG2 valid errors and
// publishes their mean with a one-cycle strobe.
module cfo_lock_metric
    import cfo_ctrl_pkg::*;
#(
    parameter int ERR_WIDTH = 24,
    parameter int WIN_LOG2  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 err_valid_i,
    input  logic [ERR_WIDTH-1:0] phase_err_i,
    output logic                 win_end,
    output logic [ERR_WIDTH-1:0] win_mean,
    output logic [ERR_WIDTH-1:0] metric_o,
    output logic                 metric_valid_o
);

    localparam int ACC_W = ERR_WIDTH + WIN_LOG2;

    logic signed [63:0]   err_sx;
    logic [ERR_WIDTH-1:0] abs_err;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_sum;
    logic [WIN_LOG2-1:0]  cnt;

    assign err_sx   = 64'(signed'(phase_err_i));
    assign abs_err  = ERR_WIDTH'(sat_abs(err_sx, ERR_WIDTH));
    assign acc_sum  = acc + ACC_W'(abs_err);
    assign win_end  = err_valid_i && (cnt == '1);
    // Mean of the window including the sample being accepted this cycle.
    assign win_mean = ERR_WIDTH'(acc_sum >> WIN_LOG2);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc            <= '0;
            cnt            <= '0;
            metric_o       <= '0;
            metric_valid_o <= 1'b0;
        end else begin
            metric_valid_o <= 1'b0;
            if (flush) begin
                acc <= '0;
                cnt <= '0;
            end else if (err_valid_i) begin
                if (win_end) begin
                    acc            <= '0;
                    cnt            <= '0;
                    metric_o       <= win_mean;
                    metric_valid_o <= 1'b1;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cfo_loop_ctrl.sv
// CFO loop acquisition/tracking sequencer: IDLE/ACQ/TRACK FSM driving loop-filter
// gains, clear and hold. Define CFO_CTRL_STATS_EN to add lock/loss/timeout counters.
module cfo_loop_ctrl
    import cfo_ctrl_pkg::*;
#(
    parameter int                   ERR_WIDTH   = 24,
    parameter int                   WIN_LOG2    = 6,
    parameter logic [ERR_WIDTH-1:0] LOCK_THR    = 24'h020000,
    parameter logic [ERR_WIDTH-1:0] UNLOCK_THR  = 24'h080000,
    parameter int                   LOCK_CNT    = 3,
    parameter int                   LOSS_CNT    = 2,
    parameter int                   ACQ_TIMEOUT = 256,
    parameter logic [SHIFT_W-1:0]   KP_SH_ACQ   = 5'd8,
    parameter logic [SHIFT_W-1:0]   KI_SH_ACQ   = 5'd14,
    parameter logic [SHIFT_W-1:0]   KP_SH_TRK   = 5'd12,
    parameter logic [SHIFT_W-1:0]   KI_SH_TRK   = 5'd20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic                 err_valid_i,
    input  logic [ERR_WIDTH-1:0] phase_err_i,
    output logic [SHIFT_W-1:0]   kp_shift_o,
    output logic [SHIFT_W-1:0]   ki_shift_o,
    output logic                 lf_clr_o,
    output logic                 lf_hold_o,
    output logic                 locked_o,
    output logic [1:0]           state_o,
    output logic [ERR_WIDTH-1:0] metric_o,
    output logic                 metric_valid_o
`ifdef CFO_CTRL_STATS_EN
    ,
    output logic [15:0]          lock_cnt_o,
    output logic [15:0]          loss_cnt_o,
    output logic [15:0]          timeout_cnt_o
`endif
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);
    localparam int AW = $clog2(ACQ_TIMEOUT + 1);

    cfo_state_t           state, state_nx;
    logic [GW-1:0]        good_cnt, good_nx, good_inc;
    logic [BW-1:0]        bad_cnt, bad_nx, bad_inc;
    logic [AW-1:0]        acq_win, acq_nx;
    logic                 clr_nx;
    logic                 flush;
    logic                 win_end;
    logic [ERR_WIDTH-1:0] win_mean;
    logic                 is_good, is_bad;

    // IDLE and a dropped enable both discard any partial window.
    assign flush = !enable_i || (state == IDLE);

    cfo_lock_metric #(
        .ERR_WIDTH (ERR_WIDTH),
        .WIN_LOG2  (WIN_LOG2)
    ) u_metric (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .err_valid_i    (err_valid_i),
        .phase_err_i    (phase_err_i),
        .win_end        (win_end),
        .win_mean       (win_mean),
        .metric_o       (metric_o),
        .metric_valid_o (metric_valid_o)
    );

    assign is_good = win_mean < LOCK_THR;
    assign is_bad  = win_mean > UNLOCK_THR;

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        bad_nx   = bad_cnt;
        acq_nx   = acq_win;
        clr_nx   = 1'b0;
        // Mid-band windows leave both run counters untouched.
        good_inc = is_good ? good_cnt + 1'b1 : (is_bad ? '0 : good_cnt);
        bad_inc  = is_bad  ? bad_cnt + 1'b1  : (is_good ? '0 : bad_cnt);

        if (!enable_i) begin
            state_nx = IDLE;
            good_nx  = '0;
            bad_nx   = '0;
            acq_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = ACQ;
                    clr_nx   = 1'b1;
                    good_nx  = '0;
                    bad_nx   = '0;
                    acq_nx   = '0;
                end
                ACQ: begin
                    if (win_end) begin
                        if (good_inc == GW'(LOCK_CNT)) begin
                            state_nx = TRACK;
                            good_nx  = '0;
                            bad_nx   = '0;
                            acq_nx   = '0;
                        end else if (acq_win + 1'b1 == AW'(ACQ_TIMEOUT)) begin
                            clr_nx  = 1'b1;
                            good_nx = '0;
                            bad_nx  = '0;
                            acq_nx  = '0;
                        end else begin
                            good_nx = good_inc;
                            acq_nx  = acq_win + 1'b1;
                        end
                    end
                end
                TRACK: begin
                    if (win_end) begin
                        if (bad_inc == BW'(LOSS_CNT)) begin
                            state_nx = ACQ;
                            clr_nx   = 1'b1;
                            good_nx  = '0;
                            bad_nx   = '0;
                            acq_nx   = '0;
                        end else begin
                            bad_nx = bad_inc;
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                    good_nx  = '0;
                    bad_nx   = '0;
                    acq_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            acq_win    <= '0;
            kp_shift_o <= KP_SH_ACQ;
            ki_shift_o <= KI_SH_ACQ;
            lf_clr_o   <= 1'b0;
            lf_hold_o  <= 1'b1;
            locked_o   <= 1'b0;
        end else begin
            state      <= state_nx;
            good_cnt   <= good_nx;
            bad_cnt    <= bad_nx;
            acq_win    <= acq_nx;
            kp_shift_o <= (state_nx == TRACK) ? KP_SH_TRK : KP_SH_ACQ;
            ki_shift_o <= (state_nx == TRACK) ? KI_SH_TRK : KI_SH_ACQ;
            lf_clr_o   <= clr_nx;
            lf_hold_o  <= (state_nx == IDLE);
            locked_o   <= (state_nx == TRACK);
        end
    end

    assign state_o = state;

`ifdef CFO_CTRL_STATS_EN
    logic lock_evt, loss_evt, tout_evt;

    assign lock_evt = (state == ACQ)   && (state_nx == TRACK);
    assign loss_evt = (state == TRACK) && (state_nx == ACQ);
    // The only ACQ->ACQ step that clears the filter is a timeout restart.
    assign tout_evt = (state == ACQ)   && (state_nx == ACQ) && clr_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt_o    <= '0;
            loss_cnt_o    <= '0;
            timeout_cnt_o <= '0;
        end else begin
            if (lock_evt && lock_cnt_o != 16'hFFFF)
                lock_cnt_o <= lock_cnt_o + 16'd1;
            if (loss_evt && loss_cnt_o != 16'hFFFF)
                loss_cnt_o <= loss_cnt_o + 16'd1;
            if (tout_evt && timeout_cnt_o != 16'hFFFF)
                timeout_cnt_o <= timeout_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cfo_loop_ctrl.sv
// Directed + randomized bench for cfo_loop_ctrl against a window-level reference model.
module tb_cfo_loop_ctrl;

    logic        clk = 1'b0;
    logic        rst, enable_i, err_valid_i;
    logic [23:0] phase_err_i;
    logic [4:0]  kp_shift_o, ki_shift_o;
    logic        lf_clr_o, lf_hold_o, locked_o, metric_valid_o;
    logic [1:0]  state_o;
    logic [23:0] metric_o;
`ifdef CFO_CTRL_STATS_EN
    logic [15:0] lock_cnt_o, loss_cnt_o, timeout_cnt_o;
`endif

    always #5 clk = ~clk;

    cfo_loop_ctrl #(
        .ERR_WIDTH   (24),
        .WIN_LOG2    (2),
        .LOCK_CNT    (3),
        .LOSS_CNT    (2),
        .ACQ_TIMEOUT (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable_i),
        .err_valid_i    (err_valid_i),
        .phase_err_i    (phase_err_i),
        .kp_shift_o     (kp_shift_o),
        .ki_shift_o     (ki_shift_o),
        .lf_clr_o       (lf_clr_o),
        .lf_hold_o      (lf_hold_o),
        .locked_o       (locked_o),
        .state_o        (state_o),
        .metric_o       (metric_o),
        .metric_valid_o (metric_valid_o)
`ifdef CFO_CTRL_STATS_EN
        ,
        .lock_cnt_o     (lock_cnt_o),
        .loss_cnt_o     (loss_cnt_o),
        .timeout_cnt_o  (timeout_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // reference model: state as 0/1/2, window as running sum + sample count
    int          m_st, m_good, m_bad, m_acq, m_n;
    longint      m_sum;
    logic [23:0] m_metric;
    bit          m_mv, m_clr;
`ifdef CFO_CTRL_STATS_EN
    int m_lock_n, m_loss_n, m_to_n;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    function automatic longint abs_ref(input logic [23:0] x);
        longint s;
        s = longint'($signed(x));
        if (s == -longint'(8388608)) return 8388607;
        return (s < 0) ? -s : s;
    endfunction

    task automatic model_clear();
        m_good = 0; m_bad = 0; m_acq = 0; m_n = 0; m_sum = 0;
    endtask

    task automatic model_window(input longint mean);
        bit good, bad;
        good = mean < 64'h20000;
        bad  = mean > 64'h80000;
        if (m_st == 1) begin
            if (good) m_good++; else if (bad) m_good = 0;
            if (m_good == 3) begin
                m_st = 2; model_clear();
`ifdef CFO_CTRL_STATS_EN
                if (m_lock_n < 65535) m_lock_n++;
`endif
            end else begin
                m_acq++;
                if (m_acq == 4) begin
                    m_clr = 1; model_clear();
`ifdef CFO_CTRL_STATS_EN
                    if (m_to_n < 65535) m_to_n++;
`endif
                end
            end
        end else begin
            if (bad) m_bad++; else if (good) m_bad = 0;
            if (m_bad == 2) begin
                m_st = 1; m_clr = 1; model_clear();
`ifdef CFO_CTRL_STATS_EN
                if (m_loss_n < 65535) m_loss_n++;
`endif
            end
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit v, input logic [23:0] err);
        longint mean;
        m_mv = 0; m_clr = 0;
        if (r) begin
            m_st = 0; model_clear(); m_metric = '0;
`ifdef CFO_CTRL_STATS_EN
            m_lock_n = 0; m_loss_n = 0; m_to_n = 0;
`endif
        end else if (!e) begin
            m_st = 0; model_clear();
        end else if (m_st == 0) begin
            m_st = 1; m_clr = 1; model_clear();
        end else if (v) begin
            m_sum += abs_ref(err);
            m_n++;
            if (m_n == 4) begin
                mean = m_sum / 4;
                m_metric = 24'(mean);
                m_mv = 1;
                m_sum = 0; m_n = 0;
                model_window(mean);
            end
        end
    endtask

    task automatic check_all();
        chk("state",  64'(state_o),        64'(m_st));
        chk("kp",     64'(kp_shift_o),     (m_st == 2) ? 64'd12 : 64'd8);
        chk("ki",     64'(ki_shift_o),     (m_st == 2) ? 64'd20 : 64'd14);
        chk("clr",    64'(lf_clr_o),       64'(m_clr));
        chk("hold",   64'(lf_hold_o),      64'(m_st == 0));
        chk("locked", 64'(locked_o),       64'(m_st == 2));
        chk("mvalid", 64'(metric_valid_o), 64'(m_mv));
        chk("metric", 64'(metric_o),       64'(m_metric));
`ifdef CFO_CTRL_STATS_EN
        chk("lock_cnt", 64'(lock_cnt_o),    64'(m_lock_n));
        chk("loss_cnt", 64'(loss_cnt_o),    64'(m_loss_n));
        chk("tout_cnt", 64'(timeout_cnt_o), 64'(m_to_n));
`endif
    endtask

    task automatic tick(input bit r, input bit e, input bit v, input logic [23:0] err);
        rst = r; enable_i = e; err_valid_i = v; phase_err_i = err;
        @(posedge clk);
        model_step(r, e, v, err);
        #1;
        check_all();
        cyc++;
    endtask

    initial begin
        int regime;
        bit r, e, v;
        logic [23:0] err;
        int unsigned mag;

        rst = 1'b1; enable_i = 1'b0; err_valid_i = 1'b0; phase_err_i = '0;

        // reset
        tick(1, 0, 0, 24'h0);
        tick(1, 0, 0, 24'h0);
        chk("rst_hold", 64'(lf_hold_o), 64'd1);
        chk("rst_kp",   64'(kp_shift_o), 64'd8);

        // 1: enable -> ACQ with one clear pulse
        tick(0, 1, 0, 24'h0);
        chk("t1_state", 64'(state_o), 64'd1);
        chk("t1_clr",   64'(lf_clr_o), 64'd1);
        chk("t1_hold",  64'(lf_hold_o), 64'd0);
        tick(0, 1, 0, 24'h0);
        chk("t1_clr_end", 64'(lf_clr_o), 64'd0);

        // 2: three good windows lock
        for (int i = 0; i < 12; i++) begin
            tick(0, 1, 1, 24'h000100);
            if (i % 4 == 3) begin
                chk("t2_mv",     64'(metric_valid_o), 64'd1);
                chk("t2_metric", 64'(metric_o), 64'h000100);
            end
        end
        chk("t2_state", 64'(state_o), 64'd2);
        chk("t2_kp",    64'(kp_shift_o), 64'd12);
        chk("t2_ki",    64'(ki_shift_o), 64'd20);
        chk("t2_clr",   64'(lf_clr_o), 64'd0);

        // 3: two bad windows drop lock; a mid-band window in between resets nothing
        repeat (8) tick(0, 1, 1, 24'h100000);
        chk("t3_state", 64'(state_o), 64'd1);
        chk("t3_clr",   64'(lf_clr_o), 64'd1);
        repeat (12) tick(0, 1, 1, 24'h000100);
        chk("t3_relock", 64'(state_o), 64'd2);
        repeat (4) tick(0, 1, 1, 24'h100000);
        tick(0, 1, 0, 24'h0);
        repeat (4) tick(0, 1, 1, 24'h040000);
        chk("t3_mid_state", 64'(state_o), 64'd2);
        repeat (4) tick(0, 1, 1, 24'hF00000);
        chk("t3_loss", 64'(state_o), 64'd1);

        // 4: ACQ timeout restart after 4 bad windows
        repeat (15) tick(0, 1, 1, 24'h7FFFFF);
        chk("t4_pre_clr", 64'(lf_clr_o), 64'd0);
        tick(0, 1, 1, 24'h7FFFFF);
        chk("t4_clr",   64'(lf_clr_o), 64'd1);
        chk("t4_state", 64'(state_o), 64'd1);
`ifdef CFO_CTRL_STATS_EN
        chk("t4_tout", 64'(timeout_cnt_o), 64'd1);
`endif

        // 5: abs saturation, then enable drop on a window end
        repeat (4) tick(0, 1, 1, 24'h800000);
        chk("t5_metric", 64'(metric_o), 64'h7FFFFF);
        repeat (3) tick(0, 1, 1, 24'h800000);
        tick(0, 0, 1, 24'h800000);
        chk("t5_state", 64'(state_o), 64'd0);
        chk("t5_mv",    64'(metric_valid_o), 64'd0);
        chk("t5_hold",  64'(lf_hold_o), 64'd1);

        // 6: rst mid-window discards partial sums
        tick(0, 1, 0, 24'h0);
        repeat (2) tick(0, 1, 1, 24'h000200);
        tick(1, 1, 0, 24'h0);
        tick(0, 1, 0, 24'h0);
        repeat (3) tick(0, 1, 1, 24'h000300);
        chk("t6_no_mv", 64'(metric_valid_o), 64'd0);
        tick(0, 1, 1, 24'h000300);
        chk("t6_mv",     64'(metric_valid_o), 64'd1);
        chk("t6_metric", 64'(metric_o), 64'h000300);

        // randomized traffic in error-magnitude regimes
        regime = 0;
        for (int i = 0; i < 2400; i++) begin
            if (i % 32 == 0) regime = $urandom_range(0, 3);
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 59) != 0);
            v = ($urandom_range(0, 3) != 0);
            case (regime)
                0:       mag = $urandom_range(0, 32'h1FFFF);
                1:       mag = $urandom_range(32'h30000, 32'h70000);
                2:       mag = $urandom_range(32'h100000, 32'h800000);
                default: mag = $urandom_range(0, 32'hFFFFFF);
            endcase
            err = 24'(mag);
            if ($urandom_range(0, 1) == 1) err = -err;
            tick(r, e, v, err);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
